sim_step_controller: RTL and testbench

- Sequencing stage directly upstream of the generation counter and the CA cell array.
- Turns user run/step/load commands into a paced, one-cycle generation-advance strobe (gen_tick) and an active-low load strobe (load_n), both consumed by the generation counter.
- Keeps a mirror generation count so it can halt at a programmed generation limit.
- Gates every advance on the array's ready handshake.

---
 rtl/sim_step_controller_pkg.sv | 21 ++
 rtl/sim_prescaler.sv | 33 +++
 rtl/sim_step_controller.sv | 135 +++++++++++++
 tb/tb_sim_step_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_step_controller_pkg.sv
// Shared types and default widths for the generation sequencing path.
package sim_step_controller_pkg;

    localparam int unsigned GEN_W_DEF       = 16;
    localparam int unsigned PERIOD_W_DEF    = 24;
    localparam int unsigned LOAD_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_STEP,
        ST_HALT
    } state_t;

    // States in which the controller is actively sequencing.
    function automatic logic is_busy(input state_t s);
        return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/sim_prescaler.sv
// Generation period counter: counts up to max(period,1)-1 and holds there.
module sim_prescaler
    import sim_step_controller_pkg::*;
#(
    parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
    input  logic                simClock,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                terminal_c
);

    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W-1:0] last;

    // A period of 0 behaves as a period of 1.
    always_comb begin
        last       = (period == '0) ? '0 : (period - PERIOD_W'(1));
        terminal_c = (count == last);
    end

    // Count register; holds at terminal until the owner clears it.
    always_ff @(posedge simClock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !terminal_c) begin
            count <= count + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/sim_step_controller.sv
// Turns run/step/load commands into paced gen_tick and load_n strobes.
module sim_step_controller
    import sim_step_controller_pkg::*;
#(
    parameter int unsigned PERIOD_W    = PERIOD_W_DEF,
    parameter int unsigned GEN_W       = GEN_W_DEF,
    parameter int unsigned LOAD_CYCLES = LOAD_CYCLES_DEF
) (
    input  logic                simClock,
    input  logic                reset,
    input  logic                run_en,
    input  logic                step_req,
    input  logic                load_req,
    input  logic [PERIOD_W-1:0] period,
    input  logic                limit_en,
    input  logic [GEN_W-1:0]    gen_limit,
    input  logic                array_ready,
    output logic                gen_tick,
    output logic                load_n,
    output logic [GEN_W-1:0]    gen_count,
    output logic                halted,
    output logic                busy
);

    localparam int unsigned LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    state_t            state, state_n;
    logic [LC_W-1:0]   load_cnt, load_cnt_n;
    logic [GEN_W-1:0]  gen_count_n, gen_inc;
    logic              gen_tick_n, load_n_n;
    logic              presc_clr, presc_en, presc_term;
    logic              limit_hit;

    sim_prescaler #(
        .PERIOD_W (PERIOD_W)
    ) u_prescaler (
        .simClock   (simClock),
        .reset      (reset),
        .clear      (presc_clr),
        .enable     (presc_en),
        .period     (period),
        .terminal_c (presc_term)
    );

    // Next-state and next-output decode; load_req overrides every state.
    always_comb begin
        state_n     = state;
        load_cnt_n  = load_cnt;
        gen_count_n = gen_count;
        gen_tick_n  = 1'b0;
        load_n_n    = 1'b1;
        presc_clr   = (state != ST_RUN);
        presc_en    = 1'b0;
        gen_inc     = gen_count + GEN_W'(1);
        limit_hit   = limit_en && (gen_inc == gen_limit);

        if (load_req) begin
            state_n     = ST_LOAD;
            load_cnt_n  = LC_W'(LOAD_CYCLES - 1);
            gen_count_n = '0;
            load_n_n    = 1'b0;
            presc_clr   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run_en) begin
                        state_n = ST_RUN;
                    end else if (step_req) begin
                        state_n = ST_STEP;
                    end
                end
                ST_LOAD: begin
                    if (load_cnt == '0) begin
                        state_n = ST_IDLE;
                    end else begin
                        load_cnt_n = load_cnt - LC_W'(1);
                        load_n_n   = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!run_en) begin
                        state_n   = ST_IDLE;
                        presc_clr = 1'b1;
                    end else if (presc_term && array_ready) begin
                        gen_tick_n  = 1'b1;
                        gen_count_n = gen_inc;
                        presc_clr   = 1'b1;
                        if (limit_hit) begin
                            state_n = ST_HALT;
                        end
                    end else begin
                        presc_en = 1'b1;
                    end
                end
                ST_STEP: begin
                    if (array_ready) begin
                        gen_tick_n  = 1'b1;
                        gen_count_n = gen_inc;
                        state_n     = limit_hit ? ST_HALT : ST_IDLE;
                    end
                end
                ST_HALT: begin
                    if (!limit_en) begin
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered output strobes.
    always_ff @(posedge simClock) begin
        if (reset) begin
            state     <= ST_IDLE;
            load_cnt  <= '0;
            gen_count <= '0;
            gen_tick  <= 1'b0;
            load_n    <= 1'b1;
            halted    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            load_cnt  <= load_cnt_n;
            gen_count <= gen_count_n;
            gen_tick  <= gen_tick_n;
            load_n    <= load_n_n;
            halted    <= (state_n == ST_HALT);
            busy      <= is_busy(state_n);
        end
    end

endmodule

// File: tb/tb_sim_step_controller.sv
// Scoreboard bench for sim_step_controller: expected strobes are queued, a monitor checks them.
module tb_sim_step_controller;

    localparam int unsigned GEN_W    = 16;
    localparam int unsigned PERIOD_W = 24;

    logic                simClock    = 1'b0;
    logic                reset       = 1'b1;
    logic                run_en      = 1'b0;
    logic                step_req    = 1'b0;
    logic                load_req    = 1'b0;
    logic [PERIOD_W-1:0] period      = PERIOD_W'(4);
    logic                limit_en    = 1'b0;
    logic [GEN_W-1:0]    gen_limit   = '0;
    logic                array_ready = 1'b0;
    logic                gen_tick;
    logic                load_n;
    logic [GEN_W-1:0]    gen_count;
    logic                halted;
    logic                busy;

    sim_step_controller dut (
        .simClock    (simClock),
        .reset       (reset),
        .run_en      (run_en),
        .step_req    (step_req),
        .load_req    (load_req),
        .period      (period),
        .limit_en    (limit_en),
        .gen_limit   (gen_limit),
        .array_ready (array_ready),
        .gen_tick    (gen_tick),
        .load_n      (load_n),
        .gen_count   (gen_count),
        .halted      (halted),
        .busy        (busy)
    );

    always #5 simClock = ~simClock;

    int cyc = 0;
    always @(posedge simClock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit mon_on = 1'b0;

    typedef struct {
        bit is_load;
        int at;
        int cnt;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input bit is_load, input int at, input int cnt);
        exp_t e;
        e.is_load = is_load;
        e.at      = at;
        e.cnt     = cnt;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge simClock);
    endtask

    // Load pulse: two low cycles of load_n, then idle with a cleared count.
    task automatic do_load();
        int k;
        k = cyc;
        load_req = 1'b1;
        push_ev(1'b1, k + 1, 0);
        push_ev(1'b1, k + 2, 0);
        wait_cyc(1);
        load_req = 1'b0;
        chk("load_busy", int'(busy), 1);
        wait_cyc(2);
        chk("load_done_load_n", int'(load_n), 1);
        chk("load_done_busy", int'(busy), 0);
        chk("load_done_halted", int'(halted), 0);
        chk("load_done_count", int'(gen_count), 0);
    endtask

    // Monitor: every strobe presented by the DUT must match the head of the queue.
    always @(negedge simClock) begin
        exp_t e;
        if (mon_on) begin
            if (gen_tick === 1'b1 && load_n === 1'b0) chk("tick_load_overlap", 1, 0);
            if (gen_tick === 1'b1 || load_n === 1'b0) begin
                if (q.size() == 0) begin
                    chk(gen_tick === 1'b1 ? "unexpected_tick" : "unexpected_load", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", int'(load_n === 1'b0), int'(e.is_load));
                    chk("event_cycle", cyc, e.at);
                    chk("event_count", int'(gen_count), e.cnt);
                end
            end
        end
    end

    initial begin
        int k;

        // Reset values
        wait_cyc(3);
        chk("rst_gen_tick", int'(gen_tick), 0);
        chk("rst_load_n", int'(load_n), 1);
        chk("rst_gen_count", int'(gen_count), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_busy", int'(busy), 0);
        reset  = 1'b0;
        mon_on = 1'b1;

        // Load sequence
        do_load();

        // Free run, period 4: ten ticks in 40 cycles
        k = cyc;
        period = PERIOD_W'(4);
        array_ready = 1'b1;
        run_en = 1'b1;
        for (int i = 0; i < 10; i++) push_ev(1'b0, k + 5 + 4 * i, i + 1);
        wait_cyc(41);
        run_en = 1'b0;
        wait_cyc(2);
        chk("run4_count", int'(gen_count), 10);
        chk("run4_idle_busy", int'(busy), 0);

        // Period 3 with array_ready dropped at terminal count for 5 cycles
        k = cyc;
        period = PERIOD_W'(3);
        run_en = 1'b1;
        push_ev(1'b0, k + 4, 11);
        push_ev(1'b0, k + 12, 12);
        push_ev(1'b0, k + 15, 13);
        wait_cyc(6);
        array_ready = 1'b0;
        wait_cyc(5);
        array_ready = 1'b1;
        wait_cyc(4);
        run_en = 1'b0;
        wait_cyc(2);
        chk("stall_count", int'(gen_count), 13);

        // Three single steps from IDLE
        do_load();
        for (int s = 0; s < 3; s++) begin
            k = cyc;
            step_req = 1'b1;
            push_ev(1'b0, k + 2, s + 1);
            wait_cyc(1);
            step_req = 1'b0;
            wait_cyc(4);
        end
        chk("step_count", int'(gen_count), 3);

        // step_req inside RUN is ignored
        k = cyc;
        period = PERIOD_W'(4);
        run_en = 1'b1;
        push_ev(1'b0, k + 5, 4);
        wait_cyc(2);
        step_req = 1'b1;
        wait_cyc(1);
        step_req = 1'b0;
        wait_cyc(3);
        run_en = 1'b0;
        wait_cyc(2);
        chk("run_step_count", int'(gen_count), 4);

        // Halt at limit 5, period 1
        do_load();
        k = cyc;
        limit_en = 1'b1;
        gen_limit = GEN_W'(5);
        period = PERIOD_W'(1);
        run_en = 1'b1;
        for (int i = 0; i < 5; i++) push_ev(1'b0, k + 2 + i, i + 1);
        wait_cyc(6);
        chk("limit_halted", int'(halted), 1);
        chk("limit_busy", int'(busy), 0);
        step_req = 1'b1;
        wait_cyc(1);
        step_req = 1'b0;
        wait_cyc(4);
        chk("limit_hold_halted", int'(halted), 1);
        chk("limit_hold_count", int'(gen_count), 5);
        run_en = 1'b0;
        do_load();

        // Halt at limit 2, leave HALT by clearing limit_en
        k = cyc;
        gen_limit = GEN_W'(2);
        run_en = 1'b1;
        push_ev(1'b0, k + 2, 1);
        push_ev(1'b0, k + 3, 2);
        wait_cyc(3);
        run_en = 1'b0;
        wait_cyc(2);
        chk("limit2_halted", int'(halted), 1);
        limit_en = 1'b0;
        wait_cyc(2);
        chk("unhalt_halted", int'(halted), 0);
        chk("unhalt_busy", int'(busy), 0);
        chk("unhalt_count", int'(gen_count), 2);

        // load_req on the cycle a RUN tick is pending
        k = cyc;
        period = PERIOD_W'(4);
        run_en = 1'b1;
        wait_cyc(4);
        load_req = 1'b1;
        run_en = 1'b0;
        push_ev(1'b1, k + 5, 0);
        push_ev(1'b1, k + 6, 0);
        wait_cyc(1);
        load_req = 1'b0;
        wait_cyc(3);
        chk("preempt_count", int'(gen_count), 0);
        chk("preempt_load_n", int'(load_n), 1);

        // Period 0 behaves as period 1
        k = cyc;
        period = '0;
        run_en = 1'b1;
        push_ev(1'b0, k + 2, 1);
        push_ev(1'b0, k + 3, 2);
        push_ev(1'b0, k + 4, 3);
        wait_cyc(4);
        run_en = 1'b0;
        wait_cyc(2);
        chk("period0_count", int'(gen_count), 3);

        // Reset in the middle of RUN
        k = cyc;
        period = PERIOD_W'(2);
        run_en = 1'b1;
        push_ev(1'b0, k + 3, 4);
        push_ev(1'b0, k + 5, 5);
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(1);
        chk("mid_rst_gen_tick", int'(gen_tick), 0);
        chk("mid_rst_load_n", int'(load_n), 1);
        chk("mid_rst_count", int'(gen_count), 0);
        chk("mid_rst_halted", int'(halted), 0);
        chk("mid_rst_busy", int'(busy), 0);
        reset = 1'b0;
        run_en = 1'b0;
        wait_cyc(3);

        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
